// File: rtl/memory_controller_if.sv
// memory_controller_if
// Request/response handshake bundle between a requester and memory_controller.
//   Request : ReqValid, ReqReady, ReqWrite, ReqAddr[M], ReqData[N]
//   Response: RespValid, RespReady, RespWrite, RespData[N]
// Modports:
//   master - the requester/consumer side (drives Req*, RespReady)
//   slave  - the controller side (drives ReqReady, Resp* except RespReady)
interface memory_controller_if #(
    parameter int N = 8,
    parameter int M = 2
);
    logic         ReqValid;
    logic         ReqReady;
    logic         ReqWrite;
    logic [M-1:0] ReqAddr;
    logic [N-1:0] ReqData;
    logic         RespValid;
    logic         RespReady;
    logic         RespWrite;
    logic [N-1:0] RespData;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqData, RespReady,
        input  ReqReady, RespValid, RespWrite, RespData
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqData, RespReady,
        output ReqReady, RespValid, RespWrite, RespData
    );
endinterface

// File: rtl/memory_controller.sv
// memory_controller
// Single-outstanding request controller in front of a simple Memory with a
// shared bidirectional data bus. One request is captured in IDLE, executed
// in a one-cycle WRITE or READ state, and its response is held in RESP until
// the consumer takes it.
// Ports:
//   Clock     - posedge clock
//   Reset     - synchronous, active-high
//   req_if    - request/response handshake (slave modport)
//   MemSelect - Memory cell select, always the captured address
//   MemRW     - Memory RW, 1 only while a write is being driven
//   MemData   - Memory DataBus, driven only during WRITE, else released
module memory_controller #(
    parameter int N = 8,
    parameter int M = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    memory_controller_if.slave  req_if,
    output logic [M-1:0]        MemSelect,
    output logic                MemRW,
    inout  wire  [N-1:0]        MemData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [M-1:0] addr_q;
    logic [N-1:0] data_q;
    logic         resp_valid_q;
    logic         resp_write_q;
    logic [N-1:0] resp_data_q;
    logic         mem_drive;

    // The request type is not kept in its own register: WRITE vs READ in the
    // state register already records it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_if.ReqValid) begin
                        addr_q <= req_if.ReqAddr;
                        data_q <= req_if.ReqData;
                    end
                end
                WRITE: begin
                    resp_valid_q <= 1'b1;
                    resp_write_q <= 1'b1;
                    resp_data_q  <= '0;
                end
                READ: begin
                    resp_valid_q <= 1'b1;
                    resp_write_q <= 1'b0;
                    resp_data_q  <= MemData;
                end
                RESP: begin
                    if (req_if.RespReady) begin
                        resp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_if.ReqValid) begin
                    state_d = req_if.ReqWrite ? WRITE : READ;
                end
            end
            WRITE:   state_d = RESP;
            READ:    state_d = RESP;
            RESP: begin
                if (req_if.RespReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with Reset keeps a write that is aborted in its own cycle from
    // being captured by the Memory on the closing edge.
    assign mem_drive = (state_q == WRITE) && !Reset;

    assign MemRW     = mem_drive;
    assign MemData   = mem_drive ? data_q : {N{1'bz}};
    assign MemSelect = addr_q;

    assign req_if.ReqReady  = (state_q == IDLE) && !Reset;
    assign req_if.RespValid = resp_valid_q;
    assign req_if.RespWrite = resp_write_q;
    assign req_if.RespData  = resp_data_q;

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller
// Bench for memory_controller with a behavioural Memory (4 cells of 8 bits,
// cell k powers up holding 1<<k) attached to the shared data bus, and a
// reference array of expected Memory contents.
module tb_memory_controller;
    localparam int N = 8;
    localparam int M = 2;
    localparam int CELLS = 1 << M;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [M-1:0] mem_select;
    logic         mem_rw;
    wire  [N-1:0] mem_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] cells   [CELLS];
    logic [N-1:0] ref_mem [CELLS];

    memory_controller_if #(.N(N), .M(M)) bus ();

    memory_controller #(.N(N), .M(M)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .req_if    (bus),
        .MemSelect (mem_select),
        .MemRW     (mem_rw),
        .MemData   (mem_data)
    );

    always #5 Clock = ~Clock;

    // Behavioural Memory: drives the bus in read mode, captures on posedge in write mode.
    assign mem_data = !mem_rw ? cells[mem_select] : {N{1'bz}};
    always @(posedge Clock) begin
        if (mem_rw) cells[mem_select] <= mem_data;
    end

    initial begin
        for (int k = 0; k < CELLS; k++) begin
            cells[k]   = N'(1 << k);
            ref_mem[k] = N'(1 << k);
        end
    end

    // Issues one request with RespReady held high and returns what was seen
    // at the accept cycle, the execute cycle and the response cycle.
    task automatic run_txn(input logic w, input logic [M-1:0] a, input logic [N-1:0] d,
                           output logic rdy, output logic rv0, output logic rv1,
                           output logic rw1, output logic [N-1:0] rd1);
        @(negedge Clock);
        rdy = bus.ReqReady;
        bus.ReqValid = 1'b1; bus.ReqWrite = w; bus.ReqAddr = a; bus.ReqData = d;
        bus.RespReady = 1'b1;
        @(negedge Clock);
        bus.ReqValid = 1'b0;
        rv0 = bus.RespValid;
        @(negedge Clock);
        rv1 = bus.RespValid; rw1 = bus.RespWrite; rd1 = bus.RespData;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        n_checks++; if (bus.ReqReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", bus.ReqReady); end
        n_checks++; if (bus.RespValid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b want=0", bus.RespValid); end
        n_checks++; if (bus.RespWrite !== 1'b0) begin n_fail++; $display("FAIL reset_resp_write got=%b want=0", bus.RespWrite); end
        n_checks++; if (bus.RespData !== 8'h00) begin n_fail++; $display("FAIL reset_resp_data got=%h want=00", bus.RespData); end
        n_checks++; if (mem_select !== 2'd0) begin n_fail++; $display("FAIL reset_select got=%0d want=0", mem_select); end
        n_checks++; if (mem_rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw got=%b want=0", mem_rw); end
        Reset = 1'b0;
        #1;
        n_checks++; if (bus.ReqReady !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b want=1", bus.ReqReady); end
    endtask

    task automatic test_powerup_read;
        logic rdy, rv0, rv1, rw1; logic [N-1:0] rd1;
        run_txn(1'b0, 2'd2, 8'h5A, rdy, rv0, rv1, rw1, rd1);
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL pu_ready got=%b want=1", rdy); end
        n_checks++; if (rv0 !== 1'b0) begin n_fail++; $display("FAIL pu_early_valid got=%b want=0", rv0); end
        n_checks++; if (rv1 !== 1'b1) begin n_fail++; $display("FAIL pu_valid got=%b want=1", rv1); end
        n_checks++; if (rw1 !== 1'b0) begin n_fail++; $display("FAIL pu_write got=%b want=0", rw1); end
        n_checks++; if (rd1 !== 8'h04) begin n_fail++; $display("FAIL pu_data got=%h want=04", rd1); end
    endtask

    task automatic test_write_read;
        logic rdy, rv0, rv1, rw1; logic [N-1:0] rd1;
        run_txn(1'b1, 2'd1, 8'hA5, rdy, rv0, rv1, rw1, rd1);
        ref_mem[1] = 8'hA5;
        n_checks++; if (rv1 !== 1'b1 || rw1 !== 1'b1) begin n_fail++; $display("FAIL wr_resp got valid=%b write=%b want 1 1", rv1, rw1); end
        n_checks++; if (rd1 !== 8'h00) begin n_fail++; $display("FAIL wr_resp_data got=%h want=00", rd1); end
        run_txn(1'b0, 2'd1, 8'h00, rdy, rv0, rv1, rw1, rd1);
        n_checks++; if (rv1 !== 1'b1 || rw1 !== 1'b0) begin n_fail++; $display("FAIL rd_resp got valid=%b write=%b want 1 0", rv1, rw1); end
        n_checks++; if (rd1 !== 8'hA5) begin n_fail++; $display("FAIL rd_after_wr got=%h want=a5", rd1); end
        for (int k = 0; k < CELLS; k++) begin
            n_checks++; if (cells[k] !== ref_mem[k]) begin n_fail++; $display("FAIL wr_cells[%0d] got=%h want=%h", k, cells[k], ref_mem[k]); end
        end
    endtask

    task automatic test_back_to_back;
        localparam int NREQ = 10;
        localparam int NCYC = 40;
        logic         rq_w [NREQ];
        logic [M-1:0] rq_a [NREQ];
        logic [N-1:0] rq_d [NREQ];
        logic         exp_rw  [NCYC+3];
        logic [N-1:0] exp_wd  [NCYC+3];
        logic         exp_rv  [NCYC+3];
        logic         exp_rwr [NCYC+3];
        logic [N-1:0] exp_rd  [NCYC+3];
        int idx = 0, next_ok = 0, prev_obs = -1;
        for (int i = 0; i < NREQ; i++) begin
            rq_w[i] = 1'($urandom_range(0, 1));
            rq_a[i] = M'($urandom_range(0, CELLS - 1));
            rq_d[i] = N'($urandom);
        end
        for (int c = 0; c < NCYC + 3; c++) begin
            exp_rw[c] = 0; exp_wd[c] = 0; exp_rv[c] = 0; exp_rwr[c] = 0; exp_rd[c] = 0;
        end
        bus.RespReady = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge Clock);
            if (idx < NREQ) begin
                bus.ReqValid = 1'b1; bus.ReqWrite = rq_w[idx]; bus.ReqAddr = rq_a[idx]; bus.ReqData = rq_d[idx];
            end else begin
                bus.ReqValid = 1'b0;
            end
            #1;
            n_checks++; if (mem_rw !== exp_rw[c]) begin n_fail++; $display("FAIL b2b_rw c=%0d got=%b want=%b", c, mem_rw, exp_rw[c]); end
            if (exp_rw[c]) begin
                n_checks++; if (mem_data !== exp_wd[c]) begin n_fail++; $display("FAIL b2b_bus c=%0d got=%h want=%h", c, mem_data, exp_wd[c]); end
            end
            n_checks++; if (bus.RespValid !== exp_rv[c]) begin n_fail++; $display("FAIL b2b_valid c=%0d got=%b want=%b", c, bus.RespValid, exp_rv[c]); end
            if (exp_rv[c]) begin
                n_checks++;
                if (bus.RespData !== exp_rd[c] || bus.RespWrite !== exp_rwr[c]) begin
                    n_fail++; $display("FAIL b2b_resp c=%0d got data=%h write=%b want data=%h write=%b", c, bus.RespData, bus.RespWrite, exp_rd[c], exp_rwr[c]);
                end
            end
            n_checks++; if (bus.ReqReady !== (c >= next_ok)) begin n_fail++; $display("FAIL b2b_ready c=%0d got=%b want=%b", c, bus.ReqReady, (c >= next_ok)); end
            if (bus.ReqReady && bus.ReqValid) begin
                if (prev_obs >= 0) begin
                    n_checks++; if (c - prev_obs != 3) begin n_fail++; $display("FAIL b2b_spacing c=%0d got=%0d want=3", c, c - prev_obs); end
                end
                prev_obs = c;
            end
            if (c >= next_ok && idx < NREQ) begin
                exp_rw[c+1]  = rq_w[idx];
                exp_wd[c+1]  = rq_d[idx];
                exp_rv[c+2]  = 1'b1;
                exp_rwr[c+2] = rq_w[idx];
                exp_rd[c+2]  = rq_w[idx] ? 8'h00 : ref_mem[rq_a[idx]];
                if (rq_w[idx]) ref_mem[rq_a[idx]] = rq_d[idx];
                next_ok = c + 3;
                idx++;
            end
        end
        bus.ReqValid = 1'b0;
        n_checks++; if (idx != NREQ) begin n_fail++; $display("FAIL b2b_issued got=%0d want=%0d", idx, NREQ); end
        for (int k = 0; k < CELLS; k++) begin
            n_checks++; if (cells[k] !== ref_mem[k]) begin n_fail++; $display("FAIL b2b_cells[%0d] got=%h want=%h", k, cells[k], ref_mem[k]); end
        end
    endtask

    task automatic test_resp_stall;
        logic [M-1:0] a, b;
        logic [N-1:0] want;
        a = M'($urandom_range(0, CELLS - 1));
        b = a + 1'b1;
        want = ref_mem[a];
        @(negedge Clock);
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqAddr = a; bus.ReqData = 8'h00;
        bus.RespReady = 1'b0;
        @(negedge Clock);
        bus.ReqWrite = 1'b1; bus.ReqAddr = b; bus.ReqData = ~ref_mem[b];
        @(negedge Clock);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.RespValid !== 1'b1 || bus.RespData !== want || bus.ReqReady !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold i=%0d got valid=%b data=%h ready=%b want 1 %h 0", i, bus.RespValid, bus.RespData, bus.ReqReady, want);
            end
            @(negedge Clock);
        end
        bus.RespReady = 1'b1;
        bus.ReqValid  = 1'b0;
        @(negedge Clock);
        n_checks++; if (bus.RespValid !== 1'b0 || bus.ReqReady !== 1'b1) begin n_fail++; $display("FAIL stall_release got valid=%b ready=%b want 0 1", bus.RespValid, bus.ReqReady); end
        n_checks++; if (cells[b] !== ref_mem[b]) begin n_fail++; $display("FAIL stall_ignored cell=%0d got=%h want=%h", b, cells[b], ref_mem[b]); end
    endtask

    task automatic test_reset_abort;
        logic rdy, rv0, rv1, rw1; logic [N-1:0] rd1;
        run_txn(1'b1, 2'd3, 8'h3C, rdy, rv0, rv1, rw1, rd1);
        ref_mem[3] = 8'h3C;
        @(negedge Clock);
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqAddr = 2'd3; bus.ReqData = 8'hFF;
        @(negedge Clock);
        bus.ReqValid = 1'b0;
        Reset = 1'b1;
        #1;
        n_checks++; if (mem_rw !== 1'b0) begin n_fail++; $display("FAIL abort_rw got=%b want=0", mem_rw); end
        n_checks++; if (bus.ReqReady !== 1'b0) begin n_fail++; $display("FAIL abort_ready_in_reset got=%b want=0", bus.ReqReady); end
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        n_checks++; if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0) begin n_fail++; $display("FAIL abort_idle got ready=%b valid=%b want 1 0", bus.ReqReady, bus.RespValid); end
        @(negedge Clock);
        n_checks++; if (bus.RespValid !== 1'b0) begin n_fail++; $display("FAIL abort_no_resp got=%b want=0", bus.RespValid); end
        n_checks++; if (cells[3] !== ref_mem[3]) begin n_fail++; $display("FAIL abort_cell3 got=%h want=%h", cells[3], ref_mem[3]); end
    endtask

    task automatic test_addr_change;
        logic [M-1:0] a;
        logic [N-1:0] d;
        a = M'($urandom_range(0, CELLS - 1));
        d = N'($urandom);
        if (d == ref_mem[a]) d = ~d;
        @(negedge Clock);
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqAddr = a; bus.ReqData = d;
        bus.RespReady = 1'b1;
        @(negedge Clock);
        bus.ReqValid = 1'b0; bus.ReqAddr = a ^ 2'd1; bus.ReqData = ~d;
        #1;
        n_checks++; if (mem_select !== a || mem_rw !== 1'b1 || mem_data !== d) begin
            n_fail++; $display("FAIL chg_bus got sel=%0d rw=%b data=%h want %0d 1 %h", mem_select, mem_rw, mem_data, a, d);
        end
        ref_mem[a] = d;
        @(negedge Clock);
        n_checks++; if (bus.RespValid !== 1'b1 || bus.RespWrite !== 1'b1) begin n_fail++; $display("FAIL chg_resp got valid=%b write=%b want 1 1", bus.RespValid, bus.RespWrite); end
        for (int k = 0; k < CELLS; k++) begin
            n_checks++; if (cells[k] !== ref_mem[k]) begin n_fail++; $display("FAIL chg_cells[%0d] got=%h want=%h", k, cells[k], ref_mem[k]); end
        end
        @(negedge Clock);
    endtask

    initial begin
        bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqAddr = '0; bus.ReqData = '0;
        bus.RespReady = 1'b0;
        test_reset();
        test_powerup_read();
        test_write_read();
        test_back_to_back();
        test_resp_stall();
        test_reset_abort();
        test_addr_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 Parameter N, default 8: data width, equal to the attached Memory cell width.
REQ-002 Parameter M, default 2: address width, equal to the attached Memory select width.
REQ-003 Clock  input  1: single clock, posedge-active.
REQ-004 Reset  input  1: reset, synchronous, active-high.
REQ-005 ReqValid  input  1: request present.
REQ-006 ReqReady  output  1: controller accepts the request this cycle.
REQ-007 ReqWrite  input  1: request type, 1 = write, 0 = read.
REQ-008 ReqAddr  input  M: cell address.
REQ-009 ReqData  input  N: write data, ignored for reads.
REQ-010 RespValid  output  1: response held for the consumer.
REQ-011 RespReady  input  1: consumer takes the response.
REQ-012 RespWrite  output  1: the response belongs to a write.
REQ-013 RespData  output  N: read data; all zeros for write responses.
REQ-014 MemSelect  output  M: drives the Memory Select input.
REQ-015 MemRW  output  1: drives the Memory RW input, 0 = read, 1 = write.
REQ-016 MemData  inout  N: connects to the Memory DataBus.

Function
REQ-017 The controller SHALL implement a four-state FSM: IDLE, WRITE, READ, RESP.
REQ-018 In every state except WRITE, MemRW SHALL be 0 and MemData SHALL be all-z, so the Memory never writes an unintended cell.
REQ-019 In WRITE, MemRW SHALL be 1 and MemData SHALL be driven with the captured data.
REQ-020 MemSelect SHALL equal the captured address register at all times.
REQ-021 IDLE: ReqReady = 1; on ReqValid=1, the controller SHALL capture ReqAddr, ReqData and ReqWrite, then go to WRITE (write) or READ (read).
REQ-022 ReqReady SHALL be 0 in WRITE, READ and RESP; at most one request is outstanding.
REQ-023 WRITE lasts exactly one cycle; the Memory captures the data on the closing posedge.
REQ-024 At that posedge the controller SHALL set RespValid=1, RespWrite=1, RespData=0 and go to RESP.
REQ-025 READ lasts exactly one cycle; on the closing posedge the controller SHALL register MemData into RespData, set RespValid=1, RespWrite=0 and go to RESP.
REQ-026 RESP: RespValid, RespWrite and RespData SHALL be held stable until a cycle with RespReady=1.
REQ-027 On that posedge the controller SHALL clear RespValid and go to IDLE, so one turnaround cycle with the bus released always separates requests.
REQ-028 Latency: request accept edge to RespValid high is 1 cycle; request-to-request throughput is at best one per 3 cycles.
REQ-029 ReqValid while ReqReady=0 SHALL be ignored, and ReqAddr/ReqData changes SHALL NOT affect the transaction in flight.
REQ-030 RespReady held high before RespValid SHALL be harmless; the response still appears for at least one cycle.
REQ-031 Addresses SHALL be used modulo 2^M, with no wrap or range error.
REQ-032 A read of a cell written by the immediately preceding request SHALL return the new value.

Reset
REQ-033 When Reset=1 at a posedge, the controller SHALL enter IDLE with RespValid=0, RespWrite=0, RespData=0, address register 0, data register 0, MemRW=0 and MemData all-z.
REQ-034 A reset in WRITE, READ or RESP SHALL abort the transaction with no response.
REQ-035 A write aborted before its closing posedge SHALL NOT reach the Memory.
REQ-036 ReqReady SHALL be 0 while Reset=1.
REQ-037 Memory ResetN is outside this block; the controller SHALL NOT assume any Memory contents after its own reset.

Verification
REQ-038 The bench SHALL cover: read after power-up (Memory cell k holds 1<<k), ReqAddr=2 -> RespData=8'h04, RespWrite=0, RespValid 1 cycle after accept.
REQ-039 The bench SHALL cover: write ReqAddr=1, ReqData=8'hA5, then read ReqAddr=1 -> write response RespData=0, RespWrite=1; read returns 8'hA5; cells 0, 2 and 3 unchanged.
REQ-040 The bench SHALL cover: back-to-back requests with ReqValid held high and RespReady=1 -> accepts spaced exactly 3 cycles; MemRW=1 only in WRITE cycles; MemData never driven by both sides.
REQ-041 The bench SHALL cover: RespReady=0 for 5 cycles after a read -> RespValid and RespData stable, ReqReady=0, and a new ReqValid ignored until release.
REQ-042 The bench SHALL cover: Reset=1 in the WRITE cycle of a write of 8'hFF to addr 3 -> no response, cell 3 keeps its prior value, controller in IDLE with ReqReady=1 one cycle after Reset drops.
REQ-043 The bench SHALL cover: write with ReqAddr changed on the cycle after accept -> the originally captured address is written.
